// File: rtl/sb_pkg.sv
// Scoreboard package: register/predicate file sizes, error-bit indices and the
// mask payload shared by the issue and writeback decoders.
package sb_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned NUM_PREDS  = 3;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned PRED_IDX_W = 2;

  // Predicate 3 is hardwired true and never tracked.
  localparam logic [PRED_IDX_W-1:0] PRED_ALWAYS = 2'd3;

  localparam int unsigned SB_ERR_W       = 3;
  localparam int unsigned SB_ERR_COLLIDE = 2;
  localparam int unsigned SB_ERR_DBLCLR  = 1;
  localparam int unsigned SB_ERR_WAW     = 0;

  // One bit per tracked register and predicate.
  typedef struct packed {
    logic [NUM_REGS-1:0]  regs;
    logic [NUM_PREDS-1:0] preds;
  } sb_mask_t;

  // One-hot predicate select; the always-true predicate maps to no bit.
  function automatic logic [NUM_PREDS-1:0] pred_onehot(input logic [PRED_IDX_W-1:0] idx);
    logic [NUM_PREDS-1:0] m;
    case (idx)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sb_mask_decode.sv
// Converts per-port (num, reg_we, pred_we) into one-hot reg/pred masks.
// dup flags two ports hitting the same tracked bit in the same cycle.
// Ports:
//   num      in  REG_IDX_W*NUM_PORTS  per-port register number (pred uses [1:0])
//   reg_we   in  NUM_PORTS            per-port register write
//   pred_we  in  NUM_PORTS            per-port predicate write
//   mask     out sb_mask_t            OR of all selected bits
//   dup      out 1                    same bit selected by more than one port
module sb_mask_decode
  import sb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [REG_IDX_W*NUM_PORTS-1:0] num,
  input  logic [NUM_PORTS-1:0]           reg_we,
  input  logic [NUM_PORTS-1:0]           pred_we,
  output sb_mask_t                       mask,
  output logic                           dup
);

  // Accumulate ports in order; a bit already present means a duplicate.
  always_comb begin
    mask = '0;
    dup  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (reg_we[i]) begin
        if (mask.regs[num[REG_IDX_W*i +: REG_IDX_W]]) begin
          dup = 1'b1;
        end
        mask.regs[num[REG_IDX_W*i +: REG_IDX_W]] = 1'b1;
      end
      if (pred_we[i]) begin
        if (|(mask.preds & pred_onehot(num[REG_IDX_W*i +: PRED_IDX_W]))) begin
          dup = 1'b1;
        end
        mask.preds = mask.preds | pred_onehot(num[REG_IDX_W*i +: PRED_IDX_W]);
      end
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Register/predicate write scoreboard for the 4-lane VLIW core. A pending bit
// is set when a lane issues a writer and cleared when that write retires.
// Ports:
//   clkrst_core_clk       in   1      core clock
//   clkrst_core_rst_n     in   1      async active-low reset
//   pc2sb_issue           in   1      packet issues this cycle
//   d2sb_rd_num           in   5*NL   per-lane destination
//   d2sb_rd_we            in   NL     per-lane register write
//   d2sb_pred_we          in   NL     per-lane predicate write (target rd_num[1:0])
//   wb2sb_rd_num          in   5*NW   per-port retiring destination
//   wb2sb_rd_we           in   NW     register write retires
//   wb2sb_pred_we         in   NW     predicate write retires
//   pc2sb_flush           in   1      discard all in-flight writers
//   sb2d_reg_scoreboard   out  32     pending register writes
//   sb2d_pred_scoreboard  out  3      pending predicate writes p0..p2
//   sb_idle               out  1      nothing pending
//   sb_err                out  3      sticky {collide, double clear, intra-packet WAW}
module scoreboard
  import sb_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_WB    = 4,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic                           clkrst_core_clk,
  input  logic                           clkrst_core_rst_n,
  input  logic                           pc2sb_issue,
  input  logic [REG_IDX_W*NUM_LANES-1:0] d2sb_rd_num,
  input  logic [NUM_LANES-1:0]           d2sb_rd_we,
  input  logic [NUM_LANES-1:0]           d2sb_pred_we,
  input  logic [REG_IDX_W*NUM_WB-1:0]    wb2sb_rd_num,
  input  logic [NUM_WB-1:0]              wb2sb_rd_we,
  input  logic [NUM_WB-1:0]              wb2sb_pred_we,
  input  logic                           pc2sb_flush,
  output logic [NUM_REGS-1:0]            sb2d_reg_scoreboard,
  output logic [NUM_PREDS-1:0]           sb2d_pred_scoreboard,
  output logic                           sb_idle,
  output logic [SB_ERR_W-1:0]            sb_err
);

  sb_mask_t              state_q;
  sb_mask_t              state_d;
  sb_mask_t              set_mask;
  sb_mask_t              clr_mask;
  sb_mask_t              visible;
  logic                  set_dup;
  logic                  clr_dup;
  logic [NUM_LANES-1:0]  iss_rd_we;
  logic [NUM_LANES-1:0]  iss_pred_we;
  logic [SB_ERR_W-1:0]   err_q;
  logic [SB_ERR_W-1:0]   err_set;

  // Lane write enables only count when the packet actually issues.
  assign iss_rd_we   = d2sb_rd_we   & {NUM_LANES{pc2sb_issue}};
  assign iss_pred_we = d2sb_pred_we & {NUM_LANES{pc2sb_issue}};

  sb_mask_decode #(
    .NUM_PORTS (NUM_LANES)
  ) u_set_decode (
    .num     (d2sb_rd_num),
    .reg_we  (iss_rd_we),
    .pred_we (iss_pred_we),
    .mask    (set_mask),
    .dup     (set_dup)
  );

  sb_mask_decode #(
    .NUM_PORTS (NUM_WB)
  ) u_clr_decode (
    .num     (wb2sb_rd_num),
    .reg_we  (wb2sb_rd_we),
    .pred_we (wb2sb_pred_we),
    .mask    (clr_mask),
    .dup     (clr_dup)
  );

  // Next state: flush wins over everything, then set wins over clear.
  always_comb begin
    state_d = '0;
    if (!pc2sb_flush) begin
      state_d = sb_mask_t'((state_q & ~clr_mask) | set_mask);
    end
  end

  // Protocol errors observed this cycle, folded into the sticky register.
  always_comb begin
    err_set                 = '0;
    err_set[SB_ERR_COLLIDE] = |(set_mask & clr_mask);
    err_set[SB_ERR_DBLCLR]  = clr_dup | (|(clr_mask & ~state_q));
    err_set[SB_ERR_WAW]     = set_dup;
  end

  // Pending state and sticky error flags.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
    end
  end

  // Bypass lets decode see a retiring source as free in the same cycle.
  if (WB_BYPASS) begin : g_bypass
    assign visible = sb_mask_t'(state_q & ~clr_mask);
  end else begin : g_no_bypass
    assign visible = state_q;
  end

  assign sb2d_reg_scoreboard  = visible.regs;
  assign sb2d_pred_scoreboard = visible.preds;
  assign sb_idle              = ~((|visible.regs) | (|visible.preds));
  assign sb_err               = err_q;

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Tracks in-flight register and predicate writes for the 4-lane VLIW core.
- Provides the sb2d_reg_scoreboard and sb2d_pred_scoreboard vectors that each lane's decode uses for dep_stall.
- Sets a pending bit when a lane issues a writer and clears it when that write retires at writeback.
- Also supports pipeline flush, drain detection for FENCE/ERET, and protocol-error flagging.

Parameters:
- NUM_LANES, 4, issue lanes per packet.
- NUM_WB, 4, writeback ports (one per lane; long-latency MULT/DIV results reuse their lane's port).
- WB_BYPASS, 1, when 1 a same-cycle writeback clear is visible on the outputs combinationally.

Ports:
- clkrst_core_clk  input  1  core clock
- clkrst_core_rst_n  input  1  asynchronous active-low reset
- pc2sb_issue  input  1  packet issues this cycle (decode not stalled, packet valid)
- d2sb_rd_num  input  5*NUM_LANES  per-lane destination register; lane i is bits [5i+4:5i]
- d2sb_rd_we  input  NUM_LANES  per-lane register write
- d2sb_pred_we  input  NUM_LANES  per-lane predicate write; target is rd_num[1:0]
- wb2sb_rd_num  input  5*NUM_WB  per-port retiring destination
- wb2sb_rd_we  input  NUM_WB  register write retires
- wb2sb_pred_we  input  NUM_WB  predicate write retires
- pc2sb_flush  input  1  pipeline kill; all in-flight writers are discarded
- sb2d_reg_scoreboard  output  32  pending register writes
- sb2d_pred_scoreboard  output  3  pending predicate writes, p0..p2
- sb_idle  output  1  no pending bits
- sb_err  output  3  sticky: {set/clear collision, double clear, intra-packet WAW}

Behaviour:
- Reset (async assert, sync deassert by clock domain):
  - Reg and pred state clear to 0.
  - sb_err clears to 0.
  - sb2d_* outputs read 0.
  - sb_idle reads 1.
- Set (on pc2sb_issue):
  - For each lane with rd_we, set reg bit rd_num.
  - For each lane with pred_we, set pred bit rd_num[1:0].
  - Predicate index 3 is the hardwired always-true predicate and is never set.
  - Set is visible the next cycle; set-to-output latency is 1.
- Clear:
  - For each valid wb port, clear reg bit or pred bit (index 3 ignored) at the clock edge.
  - With WB_BYPASS=1, outputs equal state & ~clear_mask in the same cycle (decode may issue a dependent instruction the cycle its source retires).
  - With WB_BYPASS=0, outputs equal state.
- Simultaneous set and clear of the same bit:
  - Set wins (the new writer owns the bit).
  - Raise sb_err[2].
  - Decode stalls on WAW, so this condition indicates a protocol violation.
- Clearing a bit that is already 0 raises sb_err[1].
- Intra-packet WAW: two lanes in one issuing packet setting the same reg or pred bit raises sb_err[0]; the bit is set once.
- Duplicate clears across wb ports in one cycle: OR them; the first is legal, the duplicate raises sb_err[1].
- pc2sb_flush:
  - Next state is all 0, overriding both set and clear in that cycle.
  - sb_err is not cleared.
  - The flush cycle's outputs still show the pre-flush state (with bypass if WB_BYPASS=1).
- sb_idle = ~|outputs (includes bypass); used to drain before FENCE/ERET/MTC.
- sb_err bits are sticky until reset.
- Reset asserted mid-operation: state clears immediately and asynchronously.

Decomposition:
- Package sb_pkg holds:
  - NUM_REGS=32, NUM_PREDS=3, PRED_ALWAYS=2'd3.
  - The error bit indices SB_ERR_COLLIDE=2, SB_ERR_DBLCLR=1, SB_ERR_WAW=0.
- One sub-module, sb_mask_decode: converts per-lane (num, we, pred_we) vectors into a 32-bit reg mask and a 3-bit pred mask plus a duplicate flag.
- sb_mask_decode is instantiated twice: once for the issue side and once for the writeback side.

Test Plan:
- Reset, then issue lane0 rd_we rd=5 -> cycle+1 reg_scoreboard=0x00000020, sb_idle=0; wb rd=5 with WB_BYPASS=1 -> same cycle output 0, sb_idle=1.
- Issue lane1 pred_we rd_num=2 and lane2 pred_we rd_num=3 -> pred_scoreboard=3'b100 (index 3 ignored); wb pred 2 -> 3'b000.
- Issue 4 lanes rd=1,2,3,31; next cycle wb ports clear 2 and 31 -> 0x0000000A; no sb_err.
- Same cycle: issue rd=7 and wb clears rd=7 (bit previously set) -> bit 7 remains 1, sb_err=3'b100.
- Issue lane0 and lane3 both rd=9 -> bit 9 set, sb_err[0]=1; wb rd=9 twice over two cycles -> second clear sets sb_err[1].
- Set regs 4,8 and pred 0, then pc2sb_flush together with an issue of rd=12 -> next cycle all 0, sb_idle=1; assert rst_n mid-cycle -> outputs 0 immediately, sb_err=0.
